// File: rtl/roberto_rx_serial.sv
// roberto_rx_serial: UART receiver with mid-bit sampling, start glitch rejection and stop check; odd parity when ROBERTO_RX_PARITY_EN is defined
module roberto_rx_serial #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 zera,
    input  logic                 RX,
    input  logic                 recebe_dado,
    output logic [DATA_BITS-1:0] dados_ascii,
    output logic                 pronto_recepcao,
    output logic                 tem_dado,
    output logic                 erro_frame,
    output logic                 erro_paridade,
    output logic                 erro_overrun,
    output logic [3:0]           db_estado
);
    localparam logic [3:0] st_inicial  = 4'b0000;
    localparam logic [3:0] st_start    = 4'b0001;
    localparam logic [3:0] st_dados    = 4'b0010;
`ifdef ROBERTO_RX_PARITY_EN
    localparam logic [3:0] st_paridade = 4'b0011;
`endif
    localparam logic [3:0] st_stop     = 4'b0100;
    localparam logic [3:0] st_final    = 4'b0101;
    localparam logic [3:0] st_erro     = 4'b0110;

    localparam int tw = $clog2(CLKS_PER_BIT);
    localparam int bw = $clog2(DATA_BITS + 1);
    localparam logic [tw-1:0] tick_last = tw'(CLKS_PER_BIT - 1);
    localparam logic [tw-1:0] half_last = tw'(CLKS_PER_BIT / 2 - 1);
    localparam logic [bw-1:0] bits_last = bw'(DATA_BITS - 1);

    logic [3:0]           estado;
    logic [tw-1:0]        tick;
    logic [bw-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 bit_tick;
    logic                 par_ok;

    assign bit_tick = (tick == tick_last);

`ifdef ROBERTO_RX_PARITY_EN
    logic paridade_bit;
    assign par_ok = ^{shift_reg, paridade_bit};
`else
    assign par_ok = 1'b1;
`endif

    // Report the state code; anything outside the defined set reads as 1111
    always_comb begin
        db_estado = 4'b1111;
        case (estado)
            st_inicial, st_start, st_dados, st_stop, st_final, st_erro: db_estado = estado;
`ifdef ROBERTO_RX_PARITY_EN
            st_paridade: db_estado = estado;
`endif
            default: db_estado = 4'b1111;
        endcase
    end

    // Frame FSM: outputs and pulses are registered on the stop-bit sample so they are visible during final
    always_ff @(posedge clock) begin
        if (reset || zera) begin
            estado          <= st_inicial;
            tick            <= '0;
            bit_cnt         <= '0;
            shift_reg       <= '0;
            dados_ascii     <= '0;
            tem_dado        <= 1'b0;
            pronto_recepcao <= 1'b0;
            erro_frame      <= 1'b0;
            erro_paridade   <= 1'b0;
            erro_overrun    <= 1'b0;
`ifdef ROBERTO_RX_PARITY_EN
            paridade_bit    <= 1'b0;
`endif
        end else begin
            pronto_recepcao <= 1'b0;
            erro_frame      <= 1'b0;
            erro_paridade   <= 1'b0;
            erro_overrun    <= 1'b0;
            tick            <= tick + 1'b1;
            if (recebe_dado)
                tem_dado <= 1'b0;
            case (estado)
                st_inicial: begin
                    tick <= '0;
                    if (!RX)
                        estado <= st_start;
                end
                st_start: begin
                    if (tick == half_last) begin
                        tick   <= '0;
                        estado <= RX ? st_inicial : st_dados;
                    end
                end
                st_dados: begin
                    if (bit_tick) begin
                        tick      <= '0;
                        shift_reg <= {RX, shift_reg[DATA_BITS-1:1]};
                        bit_cnt   <= (bit_cnt == bits_last) ? '0 : bit_cnt + 1'b1;
                        if (bit_cnt == bits_last)
`ifdef ROBERTO_RX_PARITY_EN
                            estado <= st_paridade;
`else
                            estado <= st_stop;
`endif
                    end
                end
`ifdef ROBERTO_RX_PARITY_EN
                st_paridade: begin
                    if (bit_tick) begin
                        tick         <= '0;
                        paridade_bit <= RX;
                        estado       <= st_stop;
                    end
                end
`endif
                st_stop: begin
                    if (bit_tick) begin
                        tick <= '0;
                        if (!RX) begin
                            estado     <= st_erro;
                            erro_frame <= 1'b1;
                        end else begin
                            estado <= st_final;
                            if (par_ok) begin
                                dados_ascii     <= shift_reg;
                                pronto_recepcao <= 1'b1;
                                tem_dado        <= 1'b1;
                                erro_overrun    <= tem_dado && !recebe_dado;
                            end else begin
                                erro_paridade <= 1'b1;
                            end
                        end
                    end
                end
                st_final: begin
                    tick   <= '0;
                    estado <= st_inicial;
                end
                st_erro: begin
                    tick <= '0;
                    if (RX)
                        estado <= st_inicial;
                end
                default: begin
                    tick   <= '0;
                    estado <= st_inicial;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_roberto_rx_serial.sv
// tb_roberto_rx_serial: directed and random frames against a frame-level reference model
module tb_roberto_rx_serial;
    localparam int C = 8;
    localparam int D = 7;
    localparam int H = C / 2;
`ifdef ROBERTO_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int N = D + P + 1;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         zera = 1'b0;
    logic         RX = 1'b1;
    logic         recebe_dado = 1'b0;
    logic [D-1:0] dados_ascii;
    logic         pronto_recepcao;
    logic         tem_dado;
    logic         erro_frame;
    logic         erro_paridade;
    logic         erro_overrun;
    logic [3:0]   db_estado;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pr_cnt = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;
    int ov_cnt = 0;
    int pr_cyc = 0;
    int exp_pr = 0;
    int exp_fe = 0;
    int exp_pe = 0;
    int exp_ov = 0;
    logic [D-1:0] m_dados = '0;
    logic         m_tem = 1'b0;

    roberto_rx_serial #(.CLKS_PER_BIT(C), .DATA_BITS(D)) dut (
        .clock(clock),
        .reset(reset),
        .zera(zera),
        .RX(RX),
        .recebe_dado(recebe_dado),
        .dados_ascii(dados_ascii),
        .pronto_recepcao(pronto_recepcao),
        .tem_dado(tem_dado),
        .erro_frame(erro_frame),
        .erro_paridade(erro_paridade),
        .erro_overrun(erro_overrun),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (pronto_recepcao) begin
            pr_cnt++;
            pr_cyc = cyc;
        end
        if (erro_frame) fe_cnt++;
        if (erro_paridade) pe_cnt++;
        if (erro_overrun) ov_cnt++;
    end

    function automatic logic odd_par(input logic [D-1:0] d);
        return ~^d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        check({tag, ".pronto"}, pr_cnt, exp_pr);
        check({tag, ".erro_frame"}, fe_cnt, exp_fe);
        check({tag, ".erro_paridade"}, pe_cnt, exp_pe);
        check({tag, ".erro_overrun"}, ov_cnt, exp_ov);
        check({tag, ".dados"}, dados_ascii, m_dados);
        check({tag, ".tem_dado"}, tem_dado, m_tem);
    endtask

    task automatic ack();
        recebe_dado = 1'b1;
        @(negedge clock);
        recebe_dado = 1'b0;
        m_tem = 1'b0;
    endtask

    task automatic send(input logic [D-1:0] d, input logic pbit, input logic sbit,
                        input logic ack_load, input int idle, input int low_hold);
        logic q[$];
        int   k;
        logic valid;
        q.push_back(1'b0);
        for (int j = 0; j < D; j++) q.push_back(d[j]);
        if (P == 1) q.push_back(pbit);
        q.push_back(sbit);
        k = cyc;
        for (int i = 0; i < (N + 1) * C; i++) begin
            RX = q[i / C];
            recebe_dado = ack_load && (i == H + N * C);
            @(negedge clock);
        end
        recebe_dado = 1'b0;
        valid = sbit && (P == 0 || (^{d, pbit}) == 1'b1);
        if (!sbit) exp_fe++;
        else if (!valid) exp_pe++;
        if (valid) begin
            if (m_tem && !ack_load) exp_ov++;
            exp_pr++;
            m_dados = d;
            m_tem = 1'b1;
            check("latency", pr_cyc - k, 1 + H + N * C);
        end else if (ack_load) begin
            m_tem = 1'b0;
        end
        if (low_hold == 0) begin
            RX = 1'b1;
            repeat (idle) @(negedge clock);
        end else begin
            repeat (low_hold) @(negedge clock);
        end
    endtask

    initial begin
        logic [D-1:0] d;
        logic         pg;
        logic         s;
        logic         a;
        repeat (3) @(negedge clock);
        check("rst.estado", db_estado, 4'b0000);
        check("rst.dados", dados_ascii, 0);
        check("rst.tem", tem_dado, 0);
        check("rst.pronto", pronto_recepcao, 0);
        reset = 1'b0;
        @(negedge clock);

        send(7'h41, odd_par(7'h41), 1'b1, 1'b0, 4, 0);
        check_all("A");
        ack();
        check("ack.tem", tem_dado, 0);

        RX = 1'b0;
        repeat (2) @(negedge clock);
        check("glitch.start", db_estado, 4'b0001);
        RX = 1'b1;
        repeat (6) @(negedge clock);
        check("glitch.idle", db_estado, 4'b0000);
        check_all("glitch");

        send(7'h30, odd_par(7'h30), 1'b0, 1'b0, 0, 20);
        check("ferr.held", db_estado, 4'b0110);
        check_all("ferr");
        RX = 1'b1;
        repeat (2) @(negedge clock);
        check("ferr.back", db_estado, 4'b0000);

        send(7'h41, 1'b0, 1'b1, 1'b0, 4, 0);
        check_all("par");

        send(7'h31, odd_par(7'h31), 1'b1, 1'b0, 0, 0);
        send(7'h32, odd_par(7'h32), 1'b1, 1'b0, 4, 0);
        check_all("b2b");
        ack();
        send(7'h31, odd_par(7'h31), 1'b1, 1'b0, 0, 0);
        send(7'h32, odd_par(7'h32), 1'b1, 1'b1, 4, 0);
        check_all("b2b_ack");

        d = 7'h5a;
        RX = 1'b0;
        repeat (C) @(negedge clock);
        for (int j = 0; j < 3; j++) begin
            RX = d[j];
            repeat (C) @(negedge clock);
        end
        RX = d[3];
        repeat (2) @(negedge clock);
        reset = 1'b1;
        RX = 1'b1;
        @(negedge clock);
        check("mid_rst.estado", db_estado, 4'b0000);
        check("mid_rst.dados", dados_ascii, 0);
        check("mid_rst.tem", tem_dado, 0);
        check("mid_rst.pulses", {pronto_recepcao, erro_frame, erro_paridade, erro_overrun}, 0);
        reset = 1'b0;
        m_dados = '0;
        m_tem = 1'b0;
        @(negedge clock);
        send(7'h41, odd_par(7'h41), 1'b1, 1'b0, 3, 0);
        check_all("after_rst");

        for (int r = 0; r < 24; r++) begin
            d  = D'($urandom_range(0, (1 << D) - 1));
            pg = ($urandom_range(0, 3) != 0);
            s  = ($urandom_range(0, 7) != 0);
            a  = ($urandom_range(0, 3) == 0);
            send(d, pg ? odd_par(d) : ~odd_par(d), s, a, s ? $urandom_range(0, 3) : $urandom_range(1, 3), 0);
            if ($urandom_range(0, 4) == 0) ack();
            check_all("rand");
        end

        zera = 1'b1;
        @(negedge clock);
        zera = 1'b0;
        m_dados = '0;
        m_tem = 1'b0;
        check("zera.estado", db_estado, 4'b0000);
        check("zera.dados", dados_ascii, 0);
        check("zera.tem", tem_dado, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/roberto_rx_serial.md
Name: roberto_rx_serial

Overview:
- UART receiver that sits directly upstream of the robot control unit.
- Deserialises command bytes from the host on the RX line and presents each byte on dados_ascii.
- Raises pronto_recepcao for one cycle per valid frame; the control unit consumes it, four frames per exchange.
- Mid-bit sampling with start-bit glitch rejection, stop-bit check and optional odd-parity check.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200); minimum 4.
- DATA_BITS, 7, data bits per frame, LSB first.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- zera  in  1  synchronous clear, same effect as reset
- RX  in  1  serial line, idle high; already synchronised upstream
- recebe_dado  in  1  consumer acknowledge, clears tem_dado
- dados_ascii  out  DATA_BITS  last valid received byte
- pronto_recepcao  out  1  one-cycle pulse on each valid frame
- tem_dado  out  1  level: unread byte held in dados_ascii
- erro_frame  out  1  one-cycle pulse: stop bit sampled 0
- erro_paridade  out  1  one-cycle pulse: parity mismatch
- erro_overrun  out  1  one-cycle pulse: valid frame arrived while tem_dado=1
- db_estado  out  4  current FSM state code

Behaviour:
- Reset/zera (synchronous, highest priority, any state, mid-frame included): FSM goes to inicial; bit counter, tick counter and shift register cleared.
  - All outputs go to 0: dados_ascii=0, tem_dado=0, all pulses 0, db_estado=0000.
  - A partial frame is discarded with no pulses.
- Tick counter counts 0..CLKS_PER_BIT-1; a "bit tick" occurs when it equals CLKS_PER_BIT-1. The counter restarts at 0 on every state entry.
- FSM states (db_estado code):
  - inicial (0000): wait for RX=0, then go to start.
  - start (0001): count CLKS_PER_BIT/2 cycles (integer division), then sample RX.
    - RX=0 -> dados.
    - RX=1 -> inicial (glitch rejected, no pulse).
  - dados (0010): on each bit tick, shift RX into the MSB of the shift register (LSB arrives first) and increment the bit counter.
    - After DATA_BITS samples -> paridade if the feature is enabled, else stop.
  - paridade (0011): on the bit tick, latch RX as the parity bit -> stop.
  - stop (0100): on the bit tick, sample RX.
    - RX=1 -> final.
    - RX=0 -> erro (pulse erro_frame).
  - final (0101): one cycle long.
    - Parity bad: pulse erro_paridade; dados_ascii and tem_dado unchanged.
    - Parity good (or feature off): load dados_ascii, pulse pronto_recepcao, set tem_dado; if tem_dado was already 1, also pulse erro_overrun (new data overwrites).
    - Then -> inicial.
  - erro (0110): wait for RX=1 (break or line held low), then -> inicial. Only one erro_frame pulse per bad frame.
  - Unused codes: -> inicial; db_estado=1111.
- Latency: pronto_recepcao is high in the cycle after the stop-bit sample, i.e. start-edge detect + CLKS_PER_BIT/2 + (DATA_BITS[+1]+1)*CLKS_PER_BIT + 1 cycles.
- tem_dado:
  - Cleared by recebe_dado.
  - If recebe_dado and a valid-frame load occur in the same cycle, the load wins: tem_dado=1 and no overrun is flagged.
- dados_ascii is stable between loads; it never shows partial shift contents.
- Back-to-back frames: a new start bit is detected in the first inicial cycle after final; no idle gap is required beyond the stop bit.

Optional Feature:
- Macro ROBERTO_RX_PARITY_EN.
- Defined: frame is start + DATA_BITS + odd parity + stop; the paridade state exists. Parity is good when the count of ones in data+parity is odd.
- Undefined: frame is start + DATA_BITS + stop; paridade state absent; erro_paridade tied to 0.

Test Plan (CLKS_PER_BIT=8, DATA_BITS=7, parity enabled):
- Send 'A' (0x41: data 1000001 LSB-first, parity 1, stop 1) -> pronto_recepcao one pulse, dados_ascii=0x41, tem_dado=1, no error pulses; then recebe_dado=1 -> tem_dado=0 next cycle.
- RX low for 2 cycles then high in idle -> FSM returns to inicial from start, no pulses, dados_ascii unchanged.
- Send 0x30 with stop bit forced 0 and RX held low 20 cycles -> one erro_frame pulse, no pronto_recepcao, FSM stays in erro (0110) until RX=1, then inicial.
- Send 0x41 with parity bit 0 -> one erro_paridade pulse, dados_ascii and tem_dado keep prior values.
- Send 0x31 then 0x32 back-to-back, never asserting recebe_dado -> two pronto_recepcao pulses, erro_overrun on the second, dados_ascii=0x32; repeat with recebe_dado asserted in the same cycle as the second load -> tem_dado=1, no erro_overrun.
- Assert reset during data bit 3 of a frame -> next cycle db_estado=0000, all outputs 0; a following clean 0x41 frame is received correctly.
